// File: rtl/sm_accumulator_pkg.sv
// Shared types and defaults for the bit-serial sign-magnitude accumulator.
package sm_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_ACC_WIDTH = 8;

    // Bit counter must hold values 0..acc_width.
    function automatic int cnt_width(input int acc_width);
        return $clog2(acc_width + 1);
    endfunction

endpackage

// File: rtl/sm_accumulator_adder.sv
// One-bit full adder cell used by the serial accumulation datapath.
module serial_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/sm_accumulator.sv
// Bit-serial signed accumulator: adds a sign-magnitude operand into a
// two's-complement running total, one bit per cycle, LSB first.
module sm_accumulator
    import sm_acc_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     mag,
    input  logic                 sign,
    input  logic                 clear,
    output logic [ACC_WIDTH-1:0] acc_result,
    output logic                 acc_sign,
    output logic                 out_valid,
    output logic                 overflow
);

    localparam int CNT_W = cnt_width(ACC_WIDTH);

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] op_q, op_d;
    logic                 carry_q, carry_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0] result_q, result_d;
    logic                 sign_q, sign_d;
    logic                 ovf_q, ovf_d;
    logic                 out_valid_q, out_valid_d;

    logic [ACC_WIDTH-1:0] mag_ext;
    logic [ACC_WIDTH-1:0] operand_in;
    logic [ACC_WIDTH-1:0] acc_next;
    logic                 fa_s;
    logic                 fa_cout;
    logic                 last_bit;

    assign mag_ext    = {{(ACC_WIDTH-WIDTH){1'b0}}, mag};
    assign operand_in = sign ? -mag_ext : mag_ext;

    // acc_q doubles as the total: after ACC_WIDTH rotations every bit is back in place.
    serial_full_adder u_fa (
        .a    (acc_q[0]),
        .b    (op_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign acc_next = {fa_s, acc_q[ACC_WIDTH-1:1]};
    assign last_bit = (cnt_q == CNT_W'(ACC_WIDTH - 1));
    assign in_ready = (state_q == IDLE) & ~clear;

    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        op_d        = op_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        sign_d      = sign_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    op_d    = operand_in;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d   = acc_next;
                op_d    = {op_q[0], op_q[ACC_WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    // On the MSB, carry_q is the carry in and fa_cout the carry out.
                    state_d     = DONE;
                    sign_d      = acc_next[ACC_WIDTH-1];
                    result_d    = acc_next[ACC_WIDTH-1] ? -acc_next : acc_next;
                    ovf_d       = ovf_q | (carry_q ^ fa_cout);
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clear) begin
            state_d     = IDLE;
            acc_d       = '0;
            result_d    = '0;
            sign_d      = 1'b0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            op_q        <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            sign_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            sign_q      <= sign_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign acc_result = result_q;
    assign acc_sign   = sign_q;
    assign overflow   = ovf_q;
    assign out_valid  = out_valid_q;

endmodule

// File: doc/sm_accumulator.md
# sm_accumulator

Bit-serial signed accumulator that takes the sign-magnitude output of the subtractor (magnitude plus sign bit) and adds it back into a running total. It is the "other direction" of the subtractor: the datapath adds one subtractor result per handshake into a wider two's-complement register. It reports the total in the same sign-magnitude form, with a sticky overflow flag. It sits downstream of the subtractor in the ALU datapath.

## Interface
- WIDTH, 4: operand magnitude width (matches the subtractor `result`)
- ACC_WIDTH, 8: accumulator width, two's complement internally; must be greater than WIDTH
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operand present
- in_ready  output  1  block can accept an operand this cycle
- mag  input  WIDTH  operand magnitude, unsigned
- sign  input  1  operand sign: 0 means add `mag`, 1 means subtract `mag`
- clear  input  1  synchronous clear of total and overflow
- acc_result  output  ACC_WIDTH  magnitude of total, registered
- acc_sign  output  1  sign of total, registered; 0 when total is 0
- out_valid  output  1  one-cycle pulse when the total has been updated
- overflow  output  1  sticky signed overflow, registered

## Operation
- FSM states (`state_t`): IDLE, SHIFT, DONE. Reset state is IDLE.
- in_ready = (state == IDLE) & ~clear. This is the only combinational output.
- Accept: in_valid & in_ready at a rising edge.
  - Latch operand = sign ? -zext(mag) : zext(mag), ACC_WIDTH bits.
  - Clear the carry register.
  - Load the bit counter with 0.
  - Go to SHIFT.
- SHIFT: one bit per cycle, LSB first.
  - acc_shift and operand shift registers rotate right through the 1-bit adder cell.
  - The carry register holds the carry between bits.
  - After ACC_WIDTH bits, go to DONE.
- Entering DONE, on the same edge as the last bit:
  - total = new acc value.
  - acc_sign = total[MSB].
  - acc_result = total[MSB] ? -total : total, unsigned ACC_WIDTH bits.
  - overflow |= (carry into MSB != carry out of MSB).
- DONE: out_valid = 1 for exactly one cycle, then go to IDLE.
- Wrap-around: on overflow the total wraps modulo 2^ACC_WIDTH. No saturation.
- Most-negative total, -2^(ACC_WIDTH-1): acc_result = 2^(ACC_WIDTH-1) (8'h80 for the default) with acc_sign = 1. This is legal and is not overflow.
- Operand -0 (mag = 0, sign = 1) behaves identically to +0.
- clear, in any state, at an edge:
  - total = 0, acc_result = 0, acc_sign = 0, overflow = 0, state = IDLE.
  - An in-flight operand is discarded and no out_valid is produced.
- clear together with in_valid in IDLE: clear wins and the operand is not accepted (in_ready = 0).
- in_valid while not in IDLE: ignored. The source must hold `mag`/`sign` stable until accepted.
- rst mid-operation: same effect as clear.

## Timing
- Reset values:
  - in_ready = 1
  - out_valid = 0
  - acc_result = 0
  - acc_sign = 0
  - overflow = 0
- Latency: accept at edge E0 → out_valid high in the cycle after edge E0+ACC_WIDTH. That is 8 cycles for the default.
- acc_result, acc_sign and overflow change only on the edge entering DONE, on clear, or on rst.
- Throughput: one operand per ACC_WIDTH+2 cycles. in_ready returns high in the cycle after DONE.
- No combinational path from mag/sign to any output.

## Structure
- Package sm_acc_pkg holds:
  - `state_t` enum {IDLE, SHIFT, DONE}
  - default WIDTH / ACC_WIDTH localparams
  - bit-counter width `$clog2(ACC_WIDTH+1)`
- Sub-module serial_full_adder: 1-bit full adder cell (a, b, cin → s, cout). It is instantiated once in the SHIFT datapath.
- Top module contains the FSM, shift registers, carry register, counter, output registers and magnitude conversion.

## Test plan
All scenarios use the defaults WIDTH = 4, ACC_WIDTH = 8.
1. Reset → in_ready = 1, out_valid = 0, acc_result = 0, acc_sign = 0, overflow = 0.
2. Running total:
   - Accept mag = 4, sign = 0 → acc_result = 4, acc_sign = 0.
   - Then mag = 2, sign = 1 → 2, 0.
   - Then mag = 10, sign = 1 → 8, 1.
   - out_valid pulses exactly once per operand, 8 cycles after each accept edge.
3. Overflow: nine operands of mag = 15, sign = 0 → after the 9th, acc_result = 121, acc_sign = 1, overflow = 1. Then mag = 0, sign = 0 → overflow stays 1.
4. Most-negative total: subtract 15 eight times, then subtract 8 → acc_result = 128, acc_sign = 1, overflow = 0.
5. Handshake:
   - in_valid held high continuously → accepts spaced exactly 10 cycles apart; in_ready = 0 throughout SHIFT/DONE.
   - mag = 0, sign = 1 → total unchanged, acc_sign = 0 when the total is 0.
6. Clear and reset:
   - clear asserted 3 cycles into SHIFT → no out_valid; next cycle in_ready = 1, acc_result = 0, overflow = 0.
   - clear with in_valid in IDLE → operand not accepted.
   - rst mid-SHIFT → same outputs as scenario 1.
